// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared defaults, accumulator clamp constants and state encoding for the PE
package pe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 2 * DEF_DATA_W + 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  // Returned at 64 bits; callers keep the low w bits (valid for 2 <= w <= 64).
  function automatic logic [63:0] acc_smax(input int w);
    return {64{1'b1}} >> (65 - w);
  endfunction

  function automatic logic [63:0] acc_smin(input int w);
    return ~acc_smax(w);
  endfunction

  function automatic logic [63:0] acc_umax(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// rtl/pe_mac_sat.sv - combinational multiply, extend, accumulate, overflow detect and clamp
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = 2 * DATA_W + 4,
  parameter int SATURATE = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  base,
  input  logic              signed_mode,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;
  localparam logic [63:0] SMAX64 = acc_smax(ACC_W);
  localparam logic [63:0] SMIN64 = acc_smin(ACC_W);
  localparam logic [63:0] UMAX64 = acc_umax(ACC_W);
  localparam logic [ACC_W-1:0] SMAX = SMAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMIN = SMIN64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] UMAX = UMAX64[ACC_W-1:0];

  logic [PW-1:0]    a_x;
  logic [PW-1:0]    b_x;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   wide;
  logic [ACC_W-1:0] raw;
  logic             ovf_s;
  logic             ovf_u;

  // Extending operands to 2*DATA_W makes the low PW bits of the product exact in both modes.
  assign a_x  = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
  assign b_x  = {{DATA_W{signed_mode & b[DATA_W-1]}}, b};
  assign prod = a_x * b_x;

  generate
    if (ACC_W > PW) begin : g_ext
      assign prod_ext = {{(ACC_W-PW){signed_mode & prod[PW-1]}}, prod};
    end else begin : g_noext
      assign prod_ext = prod;
    end
  endgenerate

  assign wide  = {1'b0, base} + {1'b0, prod_ext};
  assign raw   = wide[ACC_W-1:0];
  assign ovf_s = (base[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
  assign ovf_u = wide[ACC_W];
  assign ovf   = signed_mode ? ovf_s : ovf_u;

  always_comb begin
    sum = raw;
    if (SATURATE != 0 && ovf) begin
      if (!signed_mode) sum = UMAX;
      else              sum = base[ACC_W-1] ? SMIN : SMAX;
    end
  end

endmodule

// File: rtl/systolic_pe_drain.sv
// rtl/systolic_pe_drain.sv - output-stationary PE with tagged dot products and a load-then-shift drain
module systolic_pe_drain
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = 2 * DATA_W + 4,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic              first_in,
  input  logic              last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic              first_out,
  output logic              last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  input  logic              drain_en,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_valid_in,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_valid_out,
  output logic              res_pending,
  output logic              ovf,
  output logic              err_misalign,
  output logic              err_lost
);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res_q;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             mac_ovf;
  logic             beat;
  logic             accept;
  logic             capture;
  logic             own_load;

  assign beat     = a_valid_in & b_valid_in;
  assign accept   = beat & (first_in | (state == ACCUM));
  assign capture  = accept & last_in;
  assign own_load = drain_en & res_pending;
  assign base     = first_in ? '0 : acc;

  pe_mac_sat #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .a          (a_in),
    .b          (b_in),
    .base       (base),
    .signed_mode(signed_mode),
    .sum        (sum),
    .ovf        (mac_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out           <= '0;
      a_valid_out     <= 1'b0;
      first_out       <= 1'b0;
      last_out        <= 1'b0;
      b_out           <= '0;
      b_valid_out     <= 1'b0;
      state           <= IDLE;
      acc             <= '0;
      res_q           <= '0;
      res_pending     <= 1'b0;
      drain_out       <= '0;
      drain_valid_out <= 1'b0;
      ovf             <= 1'b0;
      err_misalign    <= 1'b0;
      err_lost        <= 1'b0;
    end else begin
      a_valid_out <= a_valid_in;
      b_valid_out <= b_valid_in;
      first_out   <= first_in;
      last_out    <= last_in;
      if (a_valid_in) a_out <= a_in;
      if (b_valid_in) b_out <= b_in;

      if (a_valid_in != b_valid_in) err_misalign <= 1'b1;

      if (accept) begin
        acc   <= sum;
        ovf   <= first_in ? mac_ovf : (ovf | mac_ovf);
        state <= last_in ? IDLE : ACCUM;
      end

      if (drain_en) begin
        if (res_pending) begin
          drain_out       <= res_q;
          drain_valid_out <= 1'b1;
        end else begin
          drain_out       <= drain_in;
          drain_valid_out <= drain_valid_in;
        end
      end

      // A capture racing an own-load hands the old result to the chain and keeps the new one pending.
      if (capture) begin
        res_q       <= sum;
        res_pending <= 1'b1;
        if (res_pending && !drain_en) err_lost <= 1'b1;
      end else if (own_load) begin
        res_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_drain.sv
// tb/tb_systolic_pe_drain.sv - directed bench: 4-PE saturating column plus one wrapping PE
module tb_systolic_pe_drain;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int N  = 4;

  logic clk;
  logic rst;
  logic signed_mode;
  logic drain_en;

  logic [DW-1:0] a_in [N];
  logic [DW-1:0] b_in [N];
  logic          a_v [N];
  logic          b_v [N];
  logic          f_in [N];
  logic          l_in [N];

  logic [DW-1:0] a_out [N];
  logic [DW-1:0] b_out [N];
  logic          a_vo [N];
  logic          b_vo [N];
  logic          f_out [N];
  logic          l_out [N];
  logic [AW-1:0] d_in [N];
  logic          dv_in [N];
  logic [AW-1:0] d_out [N];
  logic          dv_out [N];
  logic          pend [N];
  logic          ovf [N];
  logic          emis [N];
  logic          elost [N];

  logic [DW-1:0] w_a, w_b;
  logic          w_v, w_f, w_l;
  logic [DW-1:0] w_a_out, w_b_out;
  logic          w_a_vo, w_b_vo, w_f_out, w_l_out;
  logic [AW-1:0] w_d_out;
  logic          w_dv_out, w_pend, w_ovf, w_emis, w_elost;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d_in[0]  = '0;
  assign dv_in[0] = 1'b0;

  for (genvar g = 1; g < N; g++) begin : g_chain
    assign d_in[g]  = d_out[g-1];
    assign dv_in[g] = dv_out[g-1];
  end

  for (genvar g = 0; g < N; g++) begin : g_pe
    systolic_pe_drain #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1)) u_pe (
      .clk(clk), .rst(rst), .signed_mode(signed_mode),
      .a_in(a_in[g]), .a_valid_in(a_v[g]), .first_in(f_in[g]), .last_in(l_in[g]),
      .b_in(b_in[g]), .b_valid_in(b_v[g]),
      .a_out(a_out[g]), .a_valid_out(a_vo[g]), .first_out(f_out[g]), .last_out(l_out[g]),
      .b_out(b_out[g]), .b_valid_out(b_vo[g]),
      .drain_en(drain_en), .drain_in(d_in[g]), .drain_valid_in(dv_in[g]),
      .drain_out(d_out[g]), .drain_valid_out(dv_out[g]),
      .res_pending(pend[g]), .ovf(ovf[g]), .err_misalign(emis[g]), .err_lost(elost[g])
    );
  end

  systolic_pe_drain #(.DATA_W(DW), .ACC_W(AW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .signed_mode(signed_mode),
    .a_in(w_a), .a_valid_in(w_v), .first_in(w_f), .last_in(w_l),
    .b_in(w_b), .b_valid_in(w_v),
    .a_out(w_a_out), .a_valid_out(w_a_vo), .first_out(w_f_out), .last_out(w_l_out),
    .b_out(w_b_out), .b_valid_out(w_b_vo),
    .drain_en(drain_en), .drain_in('0), .drain_valid_in(1'b0),
    .drain_out(w_d_out), .drain_valid_out(w_dv_out),
    .res_pending(w_pend), .ovf(w_ovf), .err_misalign(w_emis), .err_lost(w_elost)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0; b_in[i] = '0; a_v[i] = 1'b0; b_v[i] = 1'b0;
      f_in[i] = 1'b0; l_in[i] = 1'b0;
    end
    w_a = '0; w_b = '0; w_v = 1'b0; w_f = 1'b0; w_l = 1'b0;
  endtask

  task automatic set_beat(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic f, input logic l);
    a_in[i] = a; b_in[i] = b; a_v[i] = 1'b1; b_v[i] = 1'b1; f_in[i] = f; l_in[i] = l;
  endtask

  task automatic beat(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic f, input logic l);
    set_beat(i, a, b, f, l);
    step();
    clear_inputs();
  endtask

  task automatic drain_once();
    drain_en = 1'b1;
    step();
    drain_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    signed_mode = 1'b0;
    drain_en = 1'b0;
    clear_inputs();
    step();
    step();

    check("rst_drain_out", 32'(d_out[3]), 32'd0);
    check("rst_drain_valid", 32'(dv_out[3]), 32'd0);
    check("rst_pending", 32'(pend[3]), 32'd0);
    check("rst_flags", 32'({ovf[3], emis[3], elost[3]}), 32'd0);
    rst = 1'b0;
    step();

    // unsigned 3*4 + 5*6 + 2*10 = 62
    beat(3, 8'd3, 8'd4, 1'b1, 1'b0);
    beat(3, 8'd5, 8'd6, 1'b0, 1'b0);
    beat(3, 8'd2, 8'd10, 1'b0, 1'b1);
    check("t1_pending", 32'(pend[3]), 32'd1);
    check("t1_ovf", 32'(ovf[3]), 32'd0);
    check("t1_fwd_a", 32'(a_out[3]), 32'd2);
    check("t1_fwd_b", 32'(b_out[3]), 32'd10);
    check("t1_fwd_tags", 32'({a_vo[3], b_vo[3], f_out[3], l_out[3]}), 32'b1101);
    drain_once();
    check("t1_result", 32'(d_out[3]), 32'd62);
    check("t1_valid", 32'(dv_out[3]), 32'd1);
    check("t1_pending_clr", 32'(pend[3]), 32'd0);
    check("t1_a_hold", 32'({a_out[3], a_vo[3]}), 32'({8'd2, 1'b0}));

    // signed (-3)*4 + 7*(-2) = -26 -> 2^20 - 26
    signed_mode = 1'b1;
    beat(3, 8'hFD, 8'd4, 1'b1, 1'b0);
    beat(3, 8'd7, 8'hFE, 1'b0, 1'b1);
    drain_once();
    check("t2_neg_result", 32'(d_out[3]), 32'd1048550);
    beat(3, 8'd9, 8'd9, 1'b1, 1'b1);
    check("t2_single_pending", 32'(pend[3]), 32'd1);
    drain_once();
    check("t2_single_result", 32'(d_out[3]), 32'd81);

    // 33 x 16129 = 532257 exceeds the 20-bit signed max 524287 on the last beat
    for (int k = 0; k < 33; k++) begin
      set_beat(3, 8'd127, 8'd127, k == 0, k == 32);
      w_a = 8'd127; w_b = 8'd127; w_v = 1'b1; w_f = (k == 0); w_l = (k == 32);
      step();
      clear_inputs();
    end
    check("t3_sat_ovf", 32'(ovf[3]), 32'd1);
    check("t3_wrap_ovf", 32'(w_ovf), 32'd1);
    drain_once();
    check("t3_sat_result", 32'(d_out[3]), 32'd524287);
    check("t3_wrap_result", 32'(w_d_out), 32'd532257);
    beat(3, 8'd1, 8'd1, 1'b1, 1'b1);
    check("t3_ovf_reload", 32'(ovf[3]), 32'd0);
    drain_once();
    check("t3_reload_result", 32'(d_out[3]), 32'd1);

    // column drain: top..bottom hold 10,20,30,40
    signed_mode = 1'b0;
    for (int i = 0; i < N; i++) set_beat(i, 8'(10 * (i + 1)), 8'd1, 1'b1, 1'b1);
    step();
    clear_inputs();
    drain_en = 1'b1;
    step();
    check("t4_drain0", 32'({dv_out[3], d_out[3]}), 32'({1'b1, 20'd40}));
    step();
    check("t4_drain1", 32'({dv_out[3], d_out[3]}), 32'({1'b1, 20'd30}));
    step();
    check("t4_drain2", 32'({dv_out[3], d_out[3]}), 32'({1'b1, 20'd20}));
    step();
    check("t4_drain3", 32'({dv_out[3], d_out[3]}), 32'({1'b1, 20'd10}));
    drain_en = 1'b0;
    check("t4_pending_all", 32'({pend[0], pend[1], pend[2], pend[3]}), 32'd0);
    step();
    check("t4_hold", 32'({dv_out[3], d_out[3]}), 32'({1'b1, 20'd10}));

    // undrained result overwritten
    beat(3, 8'd5, 8'd5, 1'b1, 1'b1);
    check("t5_lost_before", 32'(elost[3]), 32'd0);
    beat(3, 8'd6, 8'd6, 1'b1, 1'b1);
    check("t5_lost", 32'(elost[3]), 32'd1);
    drain_once();
    check("t5_lost_newval", 32'(d_out[3]), 32'd36);

    // capture racing own-load on PE 2
    beat(2, 8'd7, 8'd7, 1'b1, 1'b1);
    set_beat(2, 8'd8, 8'd8, 1'b1, 1'b1);
    drain_once();
    clear_inputs();
    check("t5_race_oldval", 32'(d_out[2]), 32'd49);
    check("t5_race_pending", 32'(pend[2]), 32'd1);
    check("t5_race_nolost", 32'(elost[2]), 32'd0);
    drain_once();
    check("t5_race_newval", 32'(d_out[2]), 32'd64);

    // misaligned valids on PE 1 mid-product: 2*3 + 1*1 = 7
    beat(1, 8'd2, 8'd3, 1'b1, 1'b0);
    a_in[1] = 8'd9; a_v[1] = 1'b1;
    step();
    clear_inputs();
    check("t6_misalign", 32'(emis[1]), 32'd1);
    beat(1, 8'd1, 8'd1, 1'b0, 1'b1);
    drain_once();
    check("t6_misalign_acc", 32'(d_out[1]), 32'd7);

    beat(1, 8'd2, 8'd2, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_drain", 32'({dv_out[1], d_out[1]}), 32'd0);
    check("t6_rst_flags", 32'({pend[1], ovf[1], emis[1], elost[1]}), 32'd0);
    check("t6_rst_fwd", 32'({a_out[1], a_vo[1], b_vo[1]}), 32'd0);
    beat(1, 8'd3, 8'd3, 1'b0, 1'b1);
    check("t6_idle_ignores", 32'(pend[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
